// File: rtl/cachelinefsm.sv
// Cache line-fill / eviction controller: latches the replacement victim,
// writes it back when valid and dirty, fetches the new line, then commits.
module cachelinefsm #(
  parameter  int NUMWAYS = 4,
  parameter  int LINELEN = 512,
  parameter  int BUSW    = 64,
  localparam int BEATS   = LINELEN / BUSW,
  localparam int BEATLEN = $clog2(BEATS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CacheMiss,
  input  logic               FlushStage,
  input  logic [NUMWAYS-1:0] VictimWay,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic               BusAck,
  output logic               BusReq,
  output logic               BusWrite,
  output logic [BEATLEN-1:0] BeatCount,
  output logic [NUMWAYS-1:0] SelWay,
  output logic               BeatWriteEn,
  output logic               ClearDirty,
  output logic               SetValid,
  output logic               LRUWriteEn,
  output logic               Stall
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    COMMIT
  } state_t;

  localparam logic [BEATLEN-1:0] LAST = BEATLEN'(BEATS - 1);

  state_t             state, state_n;
  logic [BEATLEN-1:0] beat_n;
  logic [NUMWAYS-1:0] sel_n;
  logic               start;
  logic               last;
  logic               evict;

  assign start = CacheMiss & ~FlushStage;
  assign last  = (BeatCount == LAST);
  assign evict = |(VictimWay & ValidWay & DirtyWay);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      BeatCount <= '0;
      SelWay    <= '0;
    end else begin
      state     <= state_n;
      BeatCount <= beat_n;
      SelWay    <= sel_n;
    end
  end

  always_comb begin
    state_n     = state;
    beat_n      = BeatCount;
    sel_n       = SelWay;
    BusReq      = 1'b0;
    BusWrite    = 1'b0;
    BeatWriteEn = 1'b0;
    ClearDirty  = 1'b0;
    SetValid    = 1'b0;
    LRUWriteEn  = 1'b0;
    Stall       = 1'b1;
    unique case (state)
      IDLE: begin
        Stall = start;
        if (start) begin
          sel_n   = VictimWay;
          state_n = evict ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        BusReq   = 1'b1;
        BusWrite = 1'b1;
        if (BusAck) begin
          beat_n = BeatCount + 1'b1;
          if (last) begin
            beat_n     = '0;
            ClearDirty = 1'b1;
            state_n    = FETCH;
          end
        end
      end
      FETCH: begin
        BusReq      = 1'b1;
        BeatWriteEn = BusAck;
        if (BusAck) begin
          beat_n = BeatCount + 1'b1;
          if (last) begin
            beat_n  = '0;
            state_n = COMMIT;
          end
        end
      end
      COMMIT: begin
        SetValid   = 1'b1;
        LRUWriteEn = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cachelinefsm.sv
// Scoreboard bench for cachelinefsm: stimulus queues the expected
// per-cycle output image, a negedge monitor pops and compares it.
module tb_cachelinefsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CacheMiss = 1'b0;
  logic       FlushStage = 1'b0;
  logic       BusAck = 1'b0;
  logic [3:0] VictimWay = '0;
  logic [3:0] ValidWay = '0;
  logic [3:0] DirtyWay = '0;

  logic       BusReq, BusWrite;
  logic [2:0] BeatCount;
  logic [3:0] SelWay;
  logic       BeatWriteEn, ClearDirty, SetValid, LRUWriteEn, Stall;

  cachelinefsm dut (
    .clk        (clk),
    .reset      (reset),
    .CacheMiss  (CacheMiss),
    .FlushStage (FlushStage),
    .VictimWay  (VictimWay),
    .ValidWay   (ValidWay),
    .DirtyWay   (DirtyWay),
    .BusAck     (BusAck),
    .BusReq     (BusReq),
    .BusWrite   (BusWrite),
    .BeatCount  (BeatCount),
    .SelWay     (SelWay),
    .BeatWriteEn(BeatWriteEn),
    .ClearDirty (ClearDirty),
    .SetValid   (SetValid),
    .LRUWriteEn (LRUWriteEn),
    .Stall      (Stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   nvec = 0;
  int   nbad = 0;

  logic [13:0] act;
  assign act = {BusReq, BusWrite, BeatCount, SelWay,
                BeatWriteEn, ClearDirty, SetValid, LRUWriteEn, Stall};

  function automatic logic [13:0] pk(
    input logic       req,
    input logic       wr,
    input logic [2:0] beat,
    input logic [3:0] sel,
    input logic       bwe,
    input logic       cd,
    input logic       sv,
    input logic       lru,
    input logic       stall
  );
    return {req, wr, beat, sel, bwe, cd, sv, lru, stall};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      nvec++;
      if (act !== e.v) begin
        nbad++;
        $display("FAIL %s: got req,wr,beat,sel,bwe,cd,sv,lru,stall=%b required %b",
                 e.tag, act, e.v);
      end
    end
  end

  task automatic tick(input string tag, input logic [13:0] v);
    q.push_back('{tag, v});
    @(posedge clk);
    #1;
  endtask

  task automatic wb_line(input string tag, input logic [3:0] sel);
    BusAck = 1'b1;
    for (int b = 0; b < 8; b++) begin
      VictimWay = 4'(1 << ((b + 1) % 4));
      CacheMiss = 1'b1;
      tick(tag, pk(1, 1, 3'(b), sel, 0, (b == 7), 0, 0, 1));
    end
  endtask

  task automatic fetch_line(input string tag, input logic [3:0] sel,
                            input int h1, input int h2);
    for (int b = 0; b < 8; b++) begin
      VictimWay = 4'(1 << (b % 4));
      CacheMiss = 1'(b % 2);
      if (b == h1 || b == h2) begin
        BusAck = 1'b0;
        for (int w = 0; w < 3; w++)
          tick({tag, "-wait"}, pk(1, 0, 3'(b), sel, 0, 0, 0, 0, 1));
      end
      BusAck = 1'b1;
      tick(tag, pk(1, 0, 3'(b), sel, 1, 0, 0, 0, 1));
    end
    CacheMiss = 1'b0;
    tick({tag, "-commit"}, pk(0, 0, 0, sel, 0, 0, 1, 1, 1));
  endtask

  initial begin
    @(posedge clk);
    #1;
    tick("reset", pk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    reset = 1'b0;
    tick("idle", pk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));

    // Clean miss, victim noise during the fill must not move SelWay
    VictimWay = 4'b0100; ValidWay = 4'b1111; DirtyWay = 4'b0000;
    CacheMiss = 1'b1; BusAck = 1'b1;
    tick("clean-start", pk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    fetch_line("clean-fetch", 4'b0100, -1, -1);
    tick("clean-idle", pk(0, 0, 0, 4'b0100, 0, 0, 0, 0, 0));

    // Dirty miss, then back-to-back clean miss with backpressure
    VictimWay = 4'b0010; ValidWay = 4'b1111; DirtyWay = 4'b0010;
    CacheMiss = 1'b1;
    tick("dirty-start", pk(0, 0, 0, 4'b0100, 0, 0, 0, 0, 1));
    wb_line("dirty-wb", 4'b0010);
    fetch_line("dirty-fetch", 4'b0010, -1, -1);
    VictimWay = 4'b1000; DirtyWay = 4'b0000; CacheMiss = 1'b1;
    tick("b2b-start", pk(0, 0, 0, 4'b0010, 0, 0, 0, 0, 1));
    fetch_line("bp-fetch", 4'b1000, 2, 5);
    tick("bp-idle", pk(0, 0, 0, 4'b1000, 0, 0, 0, 0, 0));

    CacheMiss = 1'b1; FlushStage = 1'b1; VictimWay = 4'b0001;
    tick("flush", pk(0, 0, 0, 4'b1000, 0, 0, 0, 0, 0));
    CacheMiss = 1'b0; FlushStage = 1'b0;
    tick("flush-after", pk(0, 0, 0, 4'b1000, 0, 0, 0, 0, 0));

    ValidWay = 4'b1110; DirtyWay = 4'b0001; VictimWay = 4'b0001;
    CacheMiss = 1'b1;
    tick("invdirty-start", pk(0, 0, 0, 4'b1000, 0, 0, 0, 0, 1));
    fetch_line("invdirty-fetch", 4'b0001, -1, -1);
    tick("invdirty-idle", pk(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0));

    // Reset lands in the middle of a fetch at beat 5
    VictimWay = 4'b0100; ValidWay = 4'b1111; DirtyWay = 4'b0000;
    CacheMiss = 1'b1; BusAck = 1'b1;
    tick("rst-start", pk(0, 0, 0, 4'b0001, 0, 0, 0, 0, 1));
    CacheMiss = 1'b0;
    for (int b = 0; b < 5; b++)
      tick("rst-fetch", pk(1, 0, 3'(b), 4'b0100, 1, 0, 0, 0, 1));
    reset = 1'b1;
    tick("rst-beat5", pk(1, 0, 3'd5, 4'b0100, 1, 0, 0, 0, 1));
    tick("rst-after", pk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    reset = 1'b0;
    tick("rst-idle", pk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      nbad++;
      $display("FAIL drain: %0d vectors left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
